// File: rtl/ppg_pkg.sv
// ppg_pkg
// Shared constants and FSM state encoding for the PPG beat detectors (IR and red channels).
// No ports; imported with "import ppg_pkg::*;".
package ppg_pkg;

   localparam int unsigned PPG_DATA_W         = 20;
   localparam int unsigned PPG_PERIOD_W       = 12;
   localparam logic [19:0] PPG_HYST           = 20'd2048;
   localparam int unsigned PPG_MIN_PERIOD     = 100;   // 0.2 s at 500 Hz
   localparam int unsigned PPG_MAX_PERIOD     = 1000;  // 2 s at 500 Hz
   localparam int unsigned PPG_SAMPLE_RATE_HZ = 500;

   // Peak/valley tracker states, kept as plain constants for legacy compatibility.
   typedef logic [1:0] ppg_state_t;
   localparam ppg_state_t INIT = 2'd0;
   localparam ppg_state_t RISE = 2'd1;
   localparam ppg_state_t FALL = 2'd2;

endpackage

// File: rtl/ir_beat_detector.sv
// ir_beat_detector
// Tracks the filtered IR pulse waveform with a hysteresis peak/valley FSM and reports, per
// accepted heartbeat, the beat period (samples between accepted peaks), peak, valley and AC swing.
// Ports:
//   CLK_Filter      in   filter-domain clock
//   rst_n           in   asynchronous active-low reset
//   Sample_Valid    in   one-cycle strobe, In_IR_Filtered holds a new sample
//   In_IR_Filtered  in   unsigned filtered IR sample
//   Beat_Pulse      out  one-cycle strobe per accepted beat
//   Beat_Period     out  samples between the last two accepted peaks
//   IR_Peak         out  last accepted peak value
//   IR_Valley       out  valley preceding the last accepted peak
//   IR_AC           out  IR_Peak - IR_Valley
//   Signal_Lost     out  set on beat timeout, cleared by the next Beat_Pulse
module ir_beat_detector
   import ppg_pkg::*;
#(
   parameter int unsigned        DATA_W     = PPG_DATA_W,
   parameter int unsigned        PERIOD_W   = PPG_PERIOD_W,
   parameter logic [DATA_W-1:0]  HYST       = DATA_W'(PPG_HYST),
   parameter int unsigned        MIN_PERIOD = PPG_MIN_PERIOD,
   parameter int unsigned        MAX_PERIOD = PPG_MAX_PERIOD
) (
   input  logic                CLK_Filter,
   input  logic                rst_n,
   input  logic                Sample_Valid,
   input  logic [DATA_W-1:0]   In_IR_Filtered,
   output logic                Beat_Pulse,
   output logic [PERIOD_W-1:0] Beat_Period,
   output logic [DATA_W-1:0]   IR_Peak,
   output logic [DATA_W-1:0]   IR_Valley,
   output logic [DATA_W-1:0]   IR_AC,
   output logic                Signal_Lost
);

   localparam logic [PERIOD_W-1:0] MinCnt = PERIOD_W'(MIN_PERIOD);
   localparam logic [PERIOD_W-1:0] MaxCnt = PERIOD_W'(MAX_PERIOD);

   ppg_state_t          state_q, state_d;
   logic [DATA_W-1:0]   run_max_q, run_max_d;
   logic [DATA_W-1:0]   run_min_q, run_min_d;
   logic [DATA_W-1:0]   valley_q, valley_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                have_peak_q, have_peak_d;

   logic                beat_pulse_q, beat_pulse_d;
   logic [PERIOD_W-1:0] beat_period_q, beat_period_d;
   logic [DATA_W-1:0]   ir_peak_q, ir_peak_d;
   logic [DATA_W-1:0]   ir_valley_q, ir_valley_d;
   logic [DATA_W-1:0]   ir_ac_q, ir_ac_d;
   logic                signal_lost_q, signal_lost_d;

   logic [DATA_W-1:0]   x;
   logic [PERIOD_W-1:0] cnt_inc;
   logic [DATA_W-1:0]   drop;   // run_max - x, only used when x <= run_max
   logic [DATA_W-1:0]   climb;  // x - run_min, only used when x >= run_min
   logic                cnt_cleared;

   assign x       = In_IR_Filtered;
   assign cnt_inc = (cnt_q >= MaxCnt) ? MaxCnt : cnt_q + 1'b1;
   assign drop    = run_max_q - x;
   assign climb   = x - run_min_q;

   always_comb begin
      state_d       = state_q;
      run_max_d     = run_max_q;
      run_min_d     = run_min_q;
      valley_d      = valley_q;
      cnt_d         = cnt_q;
      have_peak_d   = have_peak_q;
      beat_pulse_d  = 1'b0;
      beat_period_d = beat_period_q;
      ir_peak_d     = ir_peak_q;
      ir_valley_d   = ir_valley_q;
      ir_ac_d       = ir_ac_q;
      signal_lost_d = signal_lost_q;
      cnt_cleared   = 1'b0;

      if (Sample_Valid) begin
         case (state_q)
            INIT: begin
               run_max_d   = x;
               run_min_d   = x;
               valley_d    = x;
               cnt_d       = '0;
               have_peak_d = 1'b0;
               state_d     = RISE;
            end
            RISE: begin
               cnt_d = cnt_inc;
               if (x > run_max_q) begin
                  run_max_d = x;
               end else if (drop >= HYST) begin
                  run_min_d = x;
                  state_d   = FALL;
                  if (!have_peak_q) begin
                     // First peak only anchors the period count.
                     have_peak_d = 1'b1;
                     cnt_d       = '0;
                     cnt_cleared = 1'b1;
                  end else if (cnt_inc >= MinCnt) begin
                     beat_pulse_d  = 1'b1;
                     beat_period_d = cnt_inc;
                     ir_peak_d     = run_max_q;
                     ir_valley_d   = valley_q;
                     ir_ac_d       = run_max_q - valley_q;
                     signal_lost_d = 1'b0;
                     cnt_d         = '0;
                     cnt_cleared   = 1'b1;
                  end
                  // Peaks arriving too soon are dicrotic notches: no pulse, count keeps running.
               end
            end
            FALL: begin
               cnt_d = cnt_inc;
               if (x < run_min_q) begin
                  run_min_d = x;
               end else if (climb >= HYST) begin
                  valley_d  = run_min_q;
                  run_max_d = x;
                  state_d   = RISE;
               end
            end
            default: state_d = INIT;
         endcase

         // Timeout loses to a beat accepted on the same sample.
         if ((state_q == RISE || state_q == FALL) && !cnt_cleared && cnt_inc >= MaxCnt) begin
            signal_lost_d = 1'b1;
            state_d       = INIT;
         end
      end
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= INIT;
         run_max_q     <= '0;
         run_min_q     <= '0;
         valley_q      <= '0;
         cnt_q         <= '0;
         have_peak_q   <= 1'b0;
         beat_pulse_q  <= 1'b0;
         beat_period_q <= '0;
         ir_peak_q     <= '0;
         ir_valley_q   <= '0;
         ir_ac_q       <= '0;
         signal_lost_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_max_q     <= run_max_d;
         run_min_q     <= run_min_d;
         valley_q      <= valley_d;
         cnt_q         <= cnt_d;
         have_peak_q   <= have_peak_d;
         beat_pulse_q  <= beat_pulse_d;
         beat_period_q <= beat_period_d;
         ir_peak_q     <= ir_peak_d;
         ir_valley_q   <= ir_valley_d;
         ir_ac_q       <= ir_ac_d;
         signal_lost_q <= signal_lost_d;
      end
   end

   assign Beat_Pulse  = beat_pulse_q;
   assign Beat_Period = beat_period_q;
   assign IR_Peak     = ir_peak_q;
   assign IR_Valley   = ir_valley_q;
   assign IR_AC       = ir_ac_q;
   assign Signal_Lost = signal_lost_q;

endmodule

// File: tb/tb_ir_beat_detector.sv
// tb_ir_beat_detector
// Scoreboard bench: each phase pushes its hand-computed beats and timeouts (tagged with the
// index of the confirming sample) into queues; a monitor pops and compares on every Beat_Pulse
// and on every rising edge of Signal_Lost.
module tb_ir_beat_detector;

   logic        CLK_Filter;
   logic        rst_n;
   logic        Sample_Valid;
   logic [19:0] In_IR_Filtered;
   logic        Beat_Pulse;
   logic [11:0] Beat_Period;
   logic [19:0] IR_Peak;
   logic [19:0] IR_Valley;
   logic [19:0] IR_AC;
   logic        Signal_Lost;

   ir_beat_detector dut (
      .CLK_Filter     (CLK_Filter),
      .rst_n          (rst_n),
      .Sample_Valid   (Sample_Valid),
      .In_IR_Filtered (In_IR_Filtered),
      .Beat_Pulse     (Beat_Pulse),
      .Beat_Period    (Beat_Period),
      .IR_Peak        (IR_Peak),
      .IR_Valley      (IR_Valley),
      .IR_AC          (IR_AC),
      .Signal_Lost    (Signal_Lost)
   );

   initial begin
      CLK_Filter = 1'b0;
      forever #5 CLK_Filter = ~CLK_Filter;
   end

   typedef struct {
      int          idx;
      logic [11:0] period;
      logic [19:0] peak;
      logic [19:0] valley;
      logic [19:0] ac;
   } beat_t;

   beat_t beat_q[$];
   int    lost_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cur_idx = -1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (sample %0d, t=%0t)", name, act, exp,
                  cur_idx, $time);
      end
   endtask

   // Triangle 0..40000..0 with 250-sample period, optional late bump on the falling edge.
   function automatic logic [19:0] tri_val(input int n, input bit bump);
      int p;
      int v;
      p = n % 250;
      v = (p <= 125) ? 320 * p : 320 * (250 - p);
      if (bump && p > 175 && p < 185) v += (p <= 180) ? 1000 * (p - 175) : 1000 * (185 - p);
      return 20'(v);
   endfunction

   task automatic drive(input int idx, input logic [19:0] val, input int idle);
      @(negedge CLK_Filter);
      Sample_Valid   = 1'b1;
      In_IR_Filtered = val;
      cur_idx        = idx;
      if (idle > 0) begin
         @(negedge CLK_Filter);
         Sample_Valid = 1'b0;
         repeat (idle - 1) @(negedge CLK_Filter);
      end
   endtask

   task automatic end_phase(input string name);
      @(negedge CLK_Filter);
      Sample_Valid = 1'b0;
      repeat (4) @(negedge CLK_Filter);
      check({name, "_beats_left"}, beat_q.size(), 0);
      check({name, "_lost_left"}, lost_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_pulse"},  Beat_Pulse,  0);
      check({name, "_period"}, Beat_Period, 0);
      check({name, "_peak"},   IR_Peak,     0);
      check({name, "_valley"}, IR_Valley,   0);
      check({name, "_ac"},     IR_AC,       0);
      check({name, "_lost"},   Signal_Lost, 0);
   endtask

   task automatic push_beat(input int idx);
      beat_t b;
      b.idx = idx; b.period = 12'd250; b.peak = 20'd40000; b.valley = 20'd0; b.ac = 20'd40000;
      beat_q.push_back(b);
   endtask

   task automatic pulse_reset(input string name);
      @(negedge CLK_Filter);
      rst_n          = 1'b0;
      Sample_Valid   = 1'b1;      // sample presented during reset must be dropped
      In_IR_Filtered = 20'd30000;
      #1;
      check_reset_outputs(name);
      repeat (3) @(negedge CLK_Filter);
      Sample_Valid = 1'b0;
      rst_n        = 1'b1;
      cur_idx      = -1;
   endtask

   // Monitor: sample 1 time unit after the active edge.
   initial begin
      logic  prev_pulse;
      logic  prev_lost;
      beat_t e;
      prev_pulse = 1'b0;
      prev_lost  = 1'b0;
      forever begin
         @(posedge CLK_Filter);
         #1;
         if (Beat_Pulse === 1'b1) begin
            check("pulse_width", prev_pulse, 0);
            if (beat_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got pulse at sample %0d, expected none", cur_idx);
            end else begin
               e = beat_q.pop_front();
               check("beat_idx",    cur_idx,     e.idx);
               check("beat_period", Beat_Period, e.period);
               check("beat_peak",   IR_Peak,     e.peak);
               check("beat_valley", IR_Valley,   e.valley);
               check("beat_ac",     IR_AC,       e.ac);
               check("beat_lost",   Signal_Lost, 0);
            end
         end
         if (Signal_Lost === 1'b1 && prev_lost === 1'b0) begin
            if (lost_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_lost: got rise at sample %0d, expected none", cur_idx);
            end else begin
               check("lost_idx", cur_idx, lost_q.pop_front());
            end
         end
         prev_pulse = Beat_Pulse;
         prev_lost  = Signal_Lost;
      end
   end

   initial begin
      rst_n          = 1'b0;
      Sample_Valid   = 1'b0;
      In_IR_Filtered = '0;
      repeat (3) @(negedge CLK_Filter);
      #1;
      check_reset_outputs("por");
      @(negedge CLK_Filter);
      rst_n = 1'b1;

      // Clean triangle, then flat line to timeout, then triangle again to recover.
      // Peaks confirm 7 samples after each apex: first at 132 (anchor), beats every 250.
      push_beat(382); push_beat(632); push_beat(882);
      lost_q.push_back(1882);      // 1000 samples after the last accepted peak
      push_beat(1883 + 382);       // tracking restarts at 1883
      for (int n = 0; n < 2383; n++) begin
         if (n < 1000)       drive(n, tri_val(n, 1'b0), 0);
         else if (n < 1883)  drive(n, 20'd320, 0);
         else                drive(n, tri_val(n - 1883, 1'b0), 0);
      end
      end_phase("triangle_lost");

      // Mid-stream reset, then triangle with a dicrotic bump confirmed at cnt = 50.
      pulse_reset("mid_reset");
      push_beat(382); push_beat(632);
      for (int n = 0; n < 750; n++) drive(n, tri_val(n, 1'b1), 0);
      end_phase("bump");

      // Same triangle, one valid sample every 4 cycles.
      pulse_reset("reset2");
      push_beat(382); push_beat(632);
      for (int n = 0; n < 750; n++) drive(n, tri_val(n, 1'b0), 3);
      end_phase("sparse");

      // +-1000 ripple on 20000 never reaches hysteresis: timeout on sample 1000.
      pulse_reset("reset3");
      lost_q.push_back(1000);
      for (int n = 0; n < 1011; n++) drive(n, (n % 2 == 0) ? 20'd21000 : 20'd19000, 0);
      end_phase("ripple");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
